fetch_prefetch: RTL and testbench
=================================

// Module: fetch_prefetch
// PURPOSE
//  Parametrised fetch stage with decoupled instruction memory port and prefetch queue.
//  Issues pipelined, in-order requests to instruction memory through a valid/ready port with variable latency.
//  Buffers returned {PC, instruction} pairs for Decode.
//  Redirects (branch/jump from Execute) flush the queue and discard stale in-flight responses.
// PARAMETERS
//  XLEN      64  address/PC width
//  RESET_PC  0   PC loaded on reset (XLEN bits)
//  Q_DEPTH   4   prefetch queue entries (power of 2, >=2)
//  MAX_OUT   2   max outstanding imem requests (>=1)
// PORTS
//  clk             in   1     system clock
//  rst_n           in   1     asynchronous active-low reset
//  Stall_F         in   1     Decode not accepting; hold queue head
//  PCSrc_E         in   1     redirect request (branch/jump taken)
//  PCTarget_E      in   XLEN  redirect target
//  imem_req_valid  out  1     request valid
//  imem_req_ready  in   1     memory accepts request
//  imem_req_addr   out  XLEN  request address
//  imem_rsp_valid  in   1     response valid; responses in request order, always accepted
//  imem_rsp_data   in   32    response instruction
//  Valid_F         out  1     PC_F/Instr_F hold a valid instruction
//  PC_F            out  XLEN  PC of queue head
//  Instr_F         out  32    instruction at queue head
// BEHAVIOUR
//  Clock: one clock, clk. Reset: rst_n asynchronous, active-low.
//  Reset: fetch_pc=RESET_PC, queue empty, outstanding=0, drop_cnt=0.
//   Reset outputs: Valid_F=0, imem_req_valid=0, PC_F=0, Instr_F=0.
//   Reset asserted mid-transaction abandons all in-flight requests.
//   The memory is reset alongside this block.
//  Issue: imem_req_valid = !PCSrc_E && (outstanding + q_count < Q_DEPTH) && (outstanding < MAX_OUT).
//   imem_req_addr = fetch_pc.
//   On valid&&ready: fetch_pc += 4, outstanding++, push fetch_pc into in-flight PC FIFO (depth MAX_OUT).
//   The credit rule guarantees a queue slot for every response; no response is ever lost or back-pressured.
//  Response: on imem_rsp_valid, outstanding-- and pop in-flight PC.
//   If drop_cnt>0: discard the response, drop_cnt--.
//   Otherwise: push {pc, data} into the queue.
//   Issue and response in the same cycle: outstanding unchanged.
//  Output: Valid_F = queue non-empty; PC_F/Instr_F = head entry (zero when empty).
//   Pop when Valid_F && !Stall_F && !PCSrc_E.
//   Push and pop in the same cycle are both allowed.
//   Full queue plus a response is impossible by construction; assert it.
//  Redirect (PCSrc_E=1): takes priority over every other event in that cycle.
//   fetch_pc <= PCTarget_E. Queue flushed (empty next cycle).
//   No request is issued that cycle. No pop occurs that cycle.
//   drop_cnt <= outstanding minus 1 if a response arrives this cycle.
//    If the response arrives while drop_cnt>0, it counts against the old drop_cnt first.
//   Outstanding accounting still applies; a response in the redirect cycle is discarded.
//   The first request from the target issues the following cycle.
//   Back-to-back redirects: the last one wins; drop_cnt is recomputed each time.
//  Latency: redirect -> first imem_req_valid at target is 1 cycle.
//   Response -> Valid_F is 1 cycle (registered queue).
//  Arithmetic: PC increment is modulo 2^XLEN; wrap-around is allowed silently.
// CONFIGURATION
//  FETCH_MISALIGN_CHECK_EN defined:
//   Adds output Misalign_F (1 bit, reset 0).
//   Redirect target with PCTarget_E[1:0]!=0: no requests issue from that target.
//   A single queue entry {PCTarget_E, 32'h0000_0013} is pushed with Misalign_F=1 while it is head.
//   Fetch halts until the next redirect.
//  Macro undefined:
//   No Misalign_F port. Target bits [1:0] are forced to 0 before use.
// STRUCTURE
//  fetch_pkg:
//   fetch_entry_t {logic [XLEN-1:0] pc; logic [31:0] instr; logic misalign;}.
//   Constants ILEN=32 and NOP_INSTR=32'h0000_0013.
//   Counter width helper functions.
//  Sub-module fetch_fifo: generic sync FIFO with parameters WIDTH and DEPTH.
//   Ports: push, pop, flush, full, empty, count.
//   Used twice: once for the prefetch queue, once for the in-flight PC FIFO.
// TESTING
//  Zero-wait memory (ready=1, rsp 1 cycle later), RESET_PC=0:
//   PC_F sequence 0,4,8,C; Valid_F high from cycle 2.
//  Stall_F held 6 cycles with 3-cycle memory latency:
//   queue fills to Q_DEPTH=4; req_valid drops; no entry lost.
//   Release resumes in order.
//  Redirect to 0x100 with 2 outstanding:
//   both stale responses dropped.
//   Next Valid_F shows PC_F=0x100; queue empty the cycle after redirect.
//  Redirect in same cycle as response and pop:
//   response discarded; no pop; drop_cnt=outstanding-1.
//  rst_n pulsed low mid-burst (asynchronously, between clock edges):
//   all outputs 0 immediately; restart fetch at RESET_PC.
//  FETCH_MISALIGN_CHECK_EN, redirect to 0x102:
//   Misalign_F=1 with PC_F=0x102 and Instr_F=NOP; no imem request until next redirect.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types, constants and sizing helpers for the fetch stage.
// Used by fetch_fifo and fetch_prefetch (FETCH_MISALIGN_CHECK_EN selects the misalign feature).
package fetch_pkg;
    localparam int FETCH_XLEN = 64;
    localparam int ILEN = 32;
    localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [FETCH_XLEN-1:0] pc;
        logic [ILEN-1:0]       instr;
        logic                  misalign;
    } fetch_entry_t;

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction
endpackage

// File: rtl/fetch_fifo.sv
// Generic synchronous FIFO with flush; a flush in the same cycle as a push leaves
// exactly the pushed word. Output reads as zero while empty.
module fetch_fifo import fetch_pkg::*; #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int CW = cnt_w(DEPTH),
    localparam int PW = ptr_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr, wr_ptr;
    logic             do_push, do_pop;

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty && !flush;
    assign do_push = push && (flush || !full || do_pop);
    assign dout    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= do_push ? inc('0) : '0;
            count  <= do_push ? CW'(1) : '0;
        end else begin
            if (do_push) wr_ptr <= inc(wr_ptr);
            if (do_pop)  rd_ptr <= inc(rd_ptr);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[flush ? PW'(0) : wr_ptr] <= din;
    end
endmodule

// File: rtl/fetch_prefetch.sv
// Fetch stage: credit-limited in-order imem requests, prefetch queue, redirect flush.
// Optional FETCH_MISALIGN_CHECK_EN adds Misalign_F and halts on misaligned targets.
module fetch_prefetch import fetch_pkg::*; #(
    parameter int              XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              Q_DEPTH  = 4,
    parameter int              MAX_OUT  = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            Stall_F,
    input  logic            PCSrc_E,
    input  logic [XLEN-1:0] PCTarget_E,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [ILEN-1:0] imem_rsp_data,
`ifdef FETCH_MISALIGN_CHECK_EN
    output logic            Misalign_F,
`endif
    output logic            Valid_F,
    output logic [XLEN-1:0] PC_F,
    output logic [ILEN-1:0] Instr_F
);
`ifdef FETCH_MISALIGN_CHECK_EN
    localparam int EW = XLEN + ILEN + 1;
`else
    localparam int EW = XLEN + ILEN;
`endif
    localparam int QCW = cnt_w(Q_DEPTH);
    localparam int OCW = cnt_w(MAX_OUT);

    logic [XLEN-1:0] fetch_pc, target, rsp_pc;
    logic [OCW-1:0]  out_cnt, drop_cnt;
    logic [QCW-1:0]  q_count;
    logic [EW-1:0]   q_din, q_dout;
    logic            q_full, q_empty, q_push, q_pop;
    logic            pc_full, pc_empty, fire, rsp, rsp_keep, halt;

    // Outstanding requests are counted by the in-flight PC FIFO itself.
    assign imem_req_valid = rst_n && !PCSrc_E && !halt && !pc_full
                            && ((int'(out_cnt) + int'(q_count)) < Q_DEPTH);
    assign imem_req_addr  = fetch_pc;
    assign fire           = imem_req_valid && imem_req_ready;
    assign rsp            = imem_rsp_valid && !pc_empty;
    assign rsp_keep       = rsp && !PCSrc_E && (drop_cnt == '0);
    assign q_pop          = Valid_F && !Stall_F && !PCSrc_E;
    assign Valid_F        = !q_empty;

`ifdef FETCH_MISALIGN_CHECK_EN
    logic mis_target;
    assign target     = PCTarget_E;
    assign mis_target = |PCTarget_E[1:0];
    assign q_push     = (PCSrc_E && mis_target) || rsp_keep;
    assign q_din      = PCSrc_E ? {PCTarget_E, NOP_INSTR, 1'b1} : {rsp_pc, imem_rsp_data, 1'b0};
    assign {PC_F, Instr_F, Misalign_F} = q_dout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       halt <= 1'b0;
        else if (PCSrc_E) halt <= mis_target;
    end
`else
    assign target = PCTarget_E & ~XLEN'(3);
    assign q_push = rsp_keep;
    assign q_din  = {rsp_pc, imem_rsp_data};
    assign {PC_F, Instr_F} = q_dout;
    assign halt   = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       fetch_pc <= RESET_PC;
        else if (PCSrc_E) fetch_pc <= target;
        else if (fire)    fetch_pc <= fetch_pc + XLEN'(4);
    end

    // Every request still in flight at a redirect is stale; a response landing now is already discarded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                      drop_cnt <= '0;
        else if (PCSrc_E)                drop_cnt <= out_cnt - OCW'(rsp);
        else if (rsp && drop_cnt != '0)  drop_cnt <= drop_cnt - 1'b1;
    end

    fetch_fifo #(.WIDTH(XLEN), .DEPTH(MAX_OUT)) u_pc_fifo (
        .clk(clk), .rst_n(rst_n), .push(fire), .pop(rsp), .flush(1'b0),
        .din(fetch_pc), .dout(rsp_pc), .full(pc_full), .empty(pc_empty), .count(out_cnt)
    );

    fetch_fifo #(.WIDTH(EW), .DEPTH(Q_DEPTH)) u_queue (
        .clk(clk), .rst_n(rst_n), .push(q_push), .pop(q_pop), .flush(PCSrc_E),
        .din(q_din), .dout(q_dout), .full(q_full), .empty(q_empty), .count(q_count)
    );

    // Issue credit reserves a slot for every response, so a kept response never meets a full queue.
    assert property (@(posedge clk) disable iff (!rst_n) !(rsp_keep && q_full));
endmodule

// File: tb/tb_fetch_prefetch.sv
// Scoreboard bench for fetch_prefetch: randomized memory latency, stalls and redirects
// checked against a sequential-PC stream model of expected Decode deliveries.
module tb_fetch_prefetch;
    import fetch_pkg::*;

    logic        clk = 1'b0, rst_n = 1'b0, Stall_F = 1'b0, PCSrc_E = 1'b0;
    logic [63:0] PCTarget_E = '0;
    logic        imem_req_ready = 1'b1, imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        imem_req_valid, Valid_F, Misalign_F;
    logic [63:0] imem_req_addr, PC_F;
    logic [31:0] Instr_F;

    fetch_prefetch #(.XLEN(64), .RESET_PC(64'h0), .Q_DEPTH(4), .MAX_OUT(2)) dut (
        .clk(clk), .rst_n(rst_n), .Stall_F(Stall_F), .PCSrc_E(PCSrc_E), .PCTarget_E(PCTarget_E),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
`ifdef FETCH_MISALIGN_CHECK_EN
        .Misalign_F(Misalign_F),
`endif
        .Valid_F(Valid_F), .PC_F(PC_F), .Instr_F(Instr_F)
    );
`ifndef FETCH_MISALIGN_CHECK_EN
    assign Misalign_F = 1'b0;
`endif

    always #5 clk = ~clk;

    typedef struct { logic [63:0] addr; longint due; } mreq_t;
    mreq_t        mq[$];
    fetch_entry_t expq[$];
    longint       cyc = 0, last_due = 0;
    int           lat_fixed = 1, rdy_pct = 100, total = 0, bad = 0, pops = 0;
    logic [63:0]  tail = '0, req_exp = '0;
    bit           halted_m = 1'b0, prev_redir = 1'b0;

    function automatic logic [31:0] instr_of(input logic [63:0] a);
        return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h0000_1357;
    endfunction

    function automatic fetch_entry_t mk(input logic [63:0] pc);
        fetch_entry_t e;
        e.pc = pc; e.instr = instr_of(pc); e.misalign = 1'b0;
        return e;
    endfunction

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    task automatic refill();
        while (!halted_m && expq.size() < 8) begin
            tail += 64'd4;
            expq.push_back(mk(tail));
        end
    endtask

    task automatic start_stream(input logic [63:0] pc);
        expq.delete();
        halted_m = 1'b0;
        tail     = pc;
        req_exp  = pc;
        expq.push_back(mk(pc));
        refill();
    endtask

    task automatic redirect_model(input logic [63:0] t);
        fetch_entry_t e;
`ifdef FETCH_MISALIGN_CHECK_EN
        if (t[1:0] != 2'b00) begin
            expq.delete();
            e.pc = t; e.instr = NOP_INSTR; e.misalign = 1'b1;
            expq.push_back(e);
            halted_m = 1'b1;
            return;
        end
`endif
        start_stream(t & ~64'd3);
    endtask

    task automatic step(input bit st, input bit rd, input logic [63:0] t);
        @(posedge clk); #1;
        Stall_F = st; PCSrc_E = rd; PCTarget_E = t;
        if (rd) redirect_model(t);
        refill();
    endtask

    task automatic do_reset();
        @(negedge clk); #2;
        rst_n = 1'b0; Stall_F = 1'b0; PCSrc_E = 1'b0;
        #1;
        check("rst_outputs_async", {imem_req_valid, Valid_F, Misalign_F, Instr_F, PC_F}, '0);
        mq.delete(); last_due = 0; imem_rsp_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        start_stream(64'h0);
    endtask

    // Memory: in-order responses, each at least one cycle after acceptance.
    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
        #1;
        imem_rsp_valid = 1'b0;
        if (rst_n && mq.size() > 0 && mq[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = instr_of(mq[0].addr);
            void'(mq.pop_front());
        end
        imem_req_ready = ($urandom_range(99) < rdy_pct);
    end

    // Request sampler: address stream, credit limit, quiet during redirect/halt.
    initial forever begin
        mreq_t  r;
        longint lat;
        @(negedge clk);
        if (rst_n) begin
            if (PCSrc_E) check("no_req_on_redirect", imem_req_valid, 0);
            else if (halted_m) check("no_req_while_halted", imem_req_valid, 0);
            else if (imem_req_valid && imem_req_ready) begin
                check("req_addr", imem_req_addr, req_exp);
                req_exp += 64'd4;
                lat    = (lat_fixed != 0) ? longint'(lat_fixed) : longint'($urandom_range(4, 1));
                r.addr = imem_req_addr;
                r.due  = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
                last_due = r.due;
                mq.push_back(r);
            end
            check("max_outstanding", (mq.size() + int'(imem_rsp_valid)) <= 2, 1);
        end
    end

    // Output monitor: pops the expected stream on every Decode acceptance.
    initial forever begin
        fetch_entry_t e;
        @(negedge clk);
        if (!rst_n) prev_redir = 1'b0;
        else begin
            if (prev_redir) check("queue_after_redirect", Valid_F, halted_m);
            if (!Valid_F)
                check("zero_when_empty", {Misalign_F, Instr_F, PC_F}, '0);
            else if (!Stall_F && !PCSrc_E) begin
                if (expq.size() == 0) check("unexpected_entry", Valid_F, 0);
                else begin
                    e = expq.pop_front();
                    pops++;
                    check("head_entry", {Misalign_F, Instr_F, PC_F}, {e.misalign, e.instr, e.pc});
                end
            end
            prev_redir = PCSrc_E;
        end
    end

    initial begin
        logic [63:0] t;
        bit st, rd;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", {imem_req_valid, Valid_F, Misalign_F, Instr_F, PC_F}, '0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        start_stream(64'h0);
        @(negedge clk); check("valid_cycle0", Valid_F, 0);
        @(negedge clk); check("valid_cycle1", Valid_F, 0);
        @(negedge clk); check("valid_cycle2", Valid_F, 1);
        check("pc_cycle2", PC_F, 64'h0);
        repeat (6) step(0, 0, '0);

        lat_fixed = 3;
        repeat (12) step(1, 0, '0);
        @(negedge clk);
        check("stall_full_req_low", imem_req_valid, 0);
        check("stall_full_valid", Valid_F, 1);
        repeat (10) step(0, 0, '0);

        repeat (4) step(0, 0, '0);
        step(0, 1, 64'h100);
        repeat (12) step(0, 0, '0);
        step(0, 1, 64'h203);
        step(0, 1, 64'h400);
        repeat (10) step($urandom_range(1), 0, '0);
        step(0, 1, 64'hFFFF_FFFF_FFFF_FFF4);
        repeat (12) step(0, 0, '0);

        lat_fixed = 1;
        repeat (5) step(0, 0, '0);
        do_reset();
        repeat (12) step(0, 0, '0);

`ifdef FETCH_MISALIGN_CHECK_EN
        step(0, 1, 64'h102);
        repeat (8) step(0, 0, '0);
        step(0, 1, 64'h800);
        repeat (8) step(0, 0, '0);
`endif

        lat_fixed = 0; rdy_pct = 75;
        for (int i = 0; i < 3000; i++) begin
            st = ($urandom_range(99) < 30);
            rd = ($urandom_range(99) < 6);
            case ($urandom_range(3))
                0:       t = {$urandom, $urandom};
                1:       t = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(15));
                2:       t = 64'($urandom_range(4095));
                default: t = 64'($urandom_range(255)) << 2;
            endcase
            step(st, rd, t);
            if (i == 1500) do_reset();
        end
        step(0, 0, '0);
        @(negedge clk);
        check("progress", pops >= 200, 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
